// File: rtl/tlb_mmu.sv
// Fully-associative MIPS32-style TLB: registered MEM-stage translation plus
// TLBWI/TLBWR/TLBP/TLBR execution, with its own Random and Wired registers.
module tlb_mmu #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lk_req,
    input  logic [31:0]      lk_vaddr,
    input  logic             lk_store,
    output logic             lk_valid,
    output logic [31:0]      lk_paddr,
    output logic             lk_refill,
    output logic             lk_invalid,
    output logic             lk_modified,
    output logic             lk_unmapped,
    input  logic [7:0]       asid_i,
    input  logic             op_valid,
    input  logic [1:0]       op_code,
    input  logic [IDX_W-1:0] index_i,
    input  logic [31:0]      entryhi_i,
    input  logic [31:0]      entrylo0_i,
    input  logic [31:0]      entrylo1_i,
    input  logic             wired_we,
    input  logic [IDX_W-1:0] wired_i,
    output logic             op_done,
    output logic [31:0]      probe_o,
    output logic [31:0]      rd_hi_o,
    output logic [31:0]      rd_lo0_o,
    output logic [31:0]      rd_lo1_o,
    output logic [IDX_W-1:0] random_o,
    output logic [IDX_W-1:0] wired_o
);
    localparam logic [IDX_W-1:0] MAX_IDX = IDX_W'(ENTRIES - 1);

    logic [ENTRIES-1:0]       present, gbit, v0, d0, v1, d1;
    logic [ENTRIES-1:0][18:0] vpn2;
    logic [ENTRIES-1:0][7:0]  asid;
    logic [ENTRIES-1:0][19:0] pfn0, pfn1;
    logic [ENTRIES-1:0][2:0]  c0, c1;

    logic [ENTRIES-1:0] lk_hit, pr_hit;

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_match
        assign lk_hit[gi] = present[gi] && (vpn2[gi] == lk_vaddr[31:13]) &&
                            (gbit[gi] || (asid[gi] == asid_i));
        assign pr_hit[gi] = present[gi] && (vpn2[gi] == entryhi_i[31:13]) &&
                            (gbit[gi] || (asid[gi] == entryhi_i[7:0]));
    end

    logic             lk_any, pr_any;
    logic [IDX_W-1:0] lk_idx, pr_idx;

    // Descending scan so the lowest matching index is the last one assigned.
    always_comb begin
        lk_any = 1'b0;
        lk_idx = '0;
        pr_any = 1'b0;
        pr_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (lk_hit[i]) begin
                lk_any = 1'b1;
                lk_idx = IDX_W'(i);
            end
            if (pr_hit[i]) begin
                pr_any = 1'b1;
                pr_idx = IDX_W'(i);
            end
        end
    end

    logic        unmapped, sel_v, sel_d, refill_n, invalid_n, modified_n;
    logic [19:0] sel_pfn;
    logic [31:0] paddr_n;

    always_comb begin
        unmapped   = (lk_vaddr[31:30] == 2'b10);
        sel_v      = lk_vaddr[12] ? v1[lk_idx]   : v0[lk_idx];
        sel_d      = lk_vaddr[12] ? d1[lk_idx]   : d0[lk_idx];
        sel_pfn    = lk_vaddr[12] ? pfn1[lk_idx] : pfn0[lk_idx];
        refill_n   = !unmapped && !lk_any;
        invalid_n  = !unmapped && lk_any && !sel_v;
        modified_n = !unmapped && lk_any && sel_v && lk_store && !sel_d;
        if (unmapped)
            paddr_n = lk_vaddr[29] ? {3'b0, lk_vaddr[28:0]} : {1'b0, lk_vaddr[30:0]};
        else if (refill_n || invalid_n || modified_n)
            paddr_n = '0;
        else
            paddr_n = {sel_pfn, lk_vaddr[11:0]};
    end

    logic             wr_en, g_new;
    logic [IDX_W-1:0] wr_idx;
    assign wr_en  = op_valid && !op_code[1];
    assign wr_idx = op_code[0] ? random_o : index_i;
    assign g_new  = entrylo0_i[0] & entrylo1_i[0];

    logic unused_bits;
    assign unused_bits = ^{entryhi_i[12:8], entrylo0_i[31:26], entrylo1_i[31:26]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            present <= '0;
            gbit    <= '0;
            v0      <= '0;
            d0      <= '0;
            v1      <= '0;
            d1      <= '0;
            vpn2    <= '0;
            asid    <= '0;
            pfn0    <= '0;
            pfn1    <= '0;
            c0      <= '0;
            c1      <= '0;
        end else if (wr_en) begin
            present[wr_idx] <= 1'b1;
            gbit[wr_idx]    <= g_new;
            vpn2[wr_idx]    <= entryhi_i[31:13];
            asid[wr_idx]    <= entryhi_i[7:0];
            pfn0[wr_idx]    <= entrylo0_i[25:6];
            c0[wr_idx]      <= entrylo0_i[5:3];
            d0[wr_idx]      <= entrylo0_i[2];
            v0[wr_idx]      <= entrylo0_i[1];
            pfn1[wr_idx]    <= entrylo1_i[25:6];
            c1[wr_idx]      <= entrylo1_i[5:3];
            d1[wr_idx]      <= entrylo1_i[2];
            v1[wr_idx]      <= entrylo1_i[1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lk_valid    <= 1'b0;
            lk_paddr    <= '0;
            lk_refill   <= 1'b0;
            lk_invalid  <= 1'b0;
            lk_modified <= 1'b0;
            lk_unmapped <= 1'b0;
        end else begin
            lk_valid    <= lk_req;
            lk_paddr    <= lk_req ? paddr_n : '0;
            lk_refill   <= lk_req && refill_n;
            lk_invalid  <= lk_req && invalid_n;
            lk_modified <= lk_req && modified_n;
            lk_unmapped <= lk_req && unmapped;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_done  <= 1'b0;
            probe_o  <= '0;
            rd_hi_o  <= '0;
            rd_lo0_o <= '0;
            rd_lo1_o <= '0;
        end else begin
            op_done <= op_valid;
            if (op_valid && op_code == 2'b10)
                probe_o <= {~pr_any, {(31 - IDX_W){1'b0}}, pr_idx};
            if (op_valid && op_code == 2'b11) begin
                if (present[index_i]) begin
                    rd_hi_o  <= {vpn2[index_i], 5'b0, asid[index_i]};
                    rd_lo0_o <= {6'b0, pfn0[index_i], c0[index_i], d0[index_i],
                                 v0[index_i], gbit[index_i]};
                    rd_lo1_o <= {6'b0, pfn1[index_i], c1[index_i], d1[index_i],
                                 v1[index_i], gbit[index_i]};
                end else begin
                    rd_hi_o  <= '0;
                    rd_lo0_o <= '0;
                    rd_lo1_o <= '0;
                end
            end
        end
    end

    // Random wraps back to the top once it reaches Wired; a Wired write restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            random_o <= MAX_IDX;
            wired_o  <= '0;
        end else if (wired_we) begin
            wired_o  <= wired_i;
            random_o <= MAX_IDX;
        end else if (wired_o == MAX_IDX || random_o == wired_o) begin
            random_o <= MAX_IDX;
        end else begin
            random_o <= random_o - 1'b1;
        end
    end
endmodule
